// File: rtl/branch_sequencer_if.sv
// -----------------------------------------------------------------------------
// branch_sequencer_if
//   Signal bundle between the main control unit / datapath and the branch
//   sequencer. clk and reset stay plain ports on the sequencer itself.
//
//   Handshake: start is a one-cycle request with ir valid in the same cycle.
//   There is no ready signal. A request is accepted only while busy is low
//   (sequencer in IDLE). A start seen while busy is high is dropped silently.
//   Acceptance is visible as busy rising in the following cycle. A rejected
//   opcode is visible as an error pulse in the following cycle.
//
//   master: drives start/ir/con_out and observes everything else (control
//           unit or testbench).
//   slave : the sequencer.
// -----------------------------------------------------------------------------
interface branch_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  // request side
  logic                  start;
  logic [DATA_WIDTH-1:0] ir;
  logic                  con_out;
  // status
  logic                  busy;
  logic                  done;
  logic                  error;
  logic                  taken;
  // latched instruction fields
  logic [1:0]            cond_bits;
  logic [3:0]            ra_sel;
  logic [DATA_WIDTH-1:0] c_sext;
  // datapath strobes
  logic                  rout;
  logic                  con_in;
  logic                  pc_out;
  logic                  y_in;
  logic                  c_out;
  logic                  alu_add;
  logic                  z_in;
  logic                  zlow_out;
  logic                  pc_in;
  // statistics
  logic [CNT_WIDTH-1:0]  taken_cnt;
  logic [CNT_WIDTH-1:0]  nottaken_cnt;
  // debug view of the FSM state register
  logic [2:0]            state_dbg;

  modport master (
    output start, ir, con_out,
    input  busy, done, error, taken, cond_bits, ra_sel, c_sext,
    input  rout, con_in, pc_out, y_in, c_out, alu_add, z_in, zlow_out, pc_in,
    input  taken_cnt, nottaken_cnt, state_dbg
  );

  modport slave (
    input  start, ir, con_out,
    output busy, done, error, taken, cond_bits, ra_sel, c_sext,
    output rout, con_in, pc_out, y_in, c_out, alu_add, z_in, zlow_out, pc_in,
    output taken_cnt, nottaken_cnt, state_dbg
  );
endinterface

// File: rtl/branch_sequencer.sv
// -----------------------------------------------------------------------------
// branch_sequencer
//   Multi-cycle control FSM that completes conditional branches
//   (brzr/brnz/brpl/brmi). It puts Ra on the bus with the CON capture strobe.
//   It then samples the condition flip-flop. On a taken branch it runs
//   PC <= PC + sext(C) through the Y/ALU/Z path. Taken and not-taken branches
//   are counted with saturating counters.
//
//   Ports:
//     clk    system clock, rising edge
//     reset  synchronous, active-high
//     bus    branch_sequencer_if.slave:
//              start/ir/con_out in;
//              busy/done/error/taken status out;
//              cond_bits/ra_sel/c_sext latched IR fields out;
//              rout/con_in/pc_out/y_in/c_out/alu_add/z_in/zlow_out/pc_in
//                datapath strobes out;
//              taken_cnt/nottaken_cnt statistics out;
//              state_dbg current FSM state out.
//
//   Timing, with start accepted in cycle n:
//     n+1 CON, n+2 EVAL.
//     Taken:     n+3 PC, n+4 ADD, n+5 LOAD, n+6 DONE.
//     Not taken: n+3 DONE.
// -----------------------------------------------------------------------------
module branch_sequencer #(
  parameter int         DATA_WIDTH = 32,
  parameter int         CNT_WIDTH  = 16,
  parameter logic [4:0] BR_OPCODE  = 5'b10010
) (
  input logic               clk,
  input logic               reset,
  branch_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CON  = 3'd1,
    S_EVAL = 3'd2,
    S_PC   = 3'd3,
    S_ADD  = 3'd4,
    S_LOAD = 3'd5,
    S_DONE = 3'd6
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t state, state_nxt;

  logic is_branch;
  logic accept;
  logic reject;

  logic busy, done;
  logic rout, con_in, pc_out, y_in, c_out, alu_add, z_in, zlow_out, pc_in;

  logic [1:0]            cond_bits_q;
  logic [3:0]            ra_sel_q;
  logic [DATA_WIDTH-1:0] c_sext_q;
  logic                  taken_q;
  logic                  error_q;
  logic [CNT_WIDTH-1:0]  taken_cnt_q;
  logic [CNT_WIDTH-1:0]  nottaken_cnt_q;

  // IR[22:21] are not part of the branch format.
  logic unused_ir_bits;
  assign unused_ir_bits = ^bus.ir[22:21];

  assign is_branch = (bus.ir[31:27] == BR_OPCODE);
  // start only matters in IDLE. Requests arriving while busy are dropped.
  assign accept    = (state == S_IDLE) && bus.start && is_branch;
  assign reject    = (state == S_IDLE) && bus.start && !is_branch;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and strobes. The strobes depend only on the registered state,
  // so no input reaches a strobe through combinational logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    rout      = 1'b0;
    con_in    = 1'b0;
    pc_out    = 1'b0;
    y_in      = 1'b0;
    c_out     = 1'b0;
    alu_add   = 1'b0;
    z_in      = 1'b0;
    zlow_out  = 1'b0;
    pc_in     = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (accept) state_nxt = S_CON;
      end
      S_CON: begin
        rout      = 1'b1;
        con_in    = 1'b1;
        state_nxt = S_EVAL;
      end
      S_EVAL: begin
        // The CON flip-flop was loaded at the end of S_CON. Its output is
        // stable for this whole cycle.
        state_nxt = bus.con_out ? S_PC : S_DONE;
      end
      S_PC: begin
        pc_out    = 1'b1;
        y_in      = 1'b1;
        state_nxt = S_ADD;
      end
      S_ADD: begin
        c_out     = 1'b1;
        alu_add   = 1'b1;
        z_in      = 1'b1;
        state_nxt = S_LOAD;
      end
      S_LOAD: begin
        zlow_out  = 1'b1;
        pc_in     = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Latched fields, outcome flag, error pulse and statistics.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      cond_bits_q    <= '0;
      ra_sel_q       <= '0;
      c_sext_q       <= '0;
      taken_q        <= 1'b0;
      error_q        <= 1'b0;
      taken_cnt_q    <= '0;
      nottaken_cnt_q <= '0;
    end else begin
      error_q <= reject;

      if (accept) begin
        cond_bits_q <= bus.ir[20:19];
        ra_sel_q    <= bus.ir[26:23];
        c_sext_q    <= {{(DATA_WIDTH-19){bus.ir[18]}}, bus.ir[18:0]};
        taken_q     <= 1'b0;
      end

      if (state == S_EVAL && bus.con_out) begin
        taken_q <= 1'b1;
      end

      // The counters are bumped on the transition into S_DONE, so the count
      // already includes this branch in the done cycle.
      if (state == S_EVAL && !bus.con_out && nottaken_cnt_q != CNT_MAX) begin
        nottaken_cnt_q <= nottaken_cnt_q + CNT_ONE;
      end
      if (state == S_LOAD && taken_cnt_q != CNT_MAX) begin
        taken_cnt_q <= taken_cnt_q + CNT_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Drive the interface
  // ---------------------------------------------------------------------------
  assign bus.busy         = busy;
  assign bus.done         = done;
  assign bus.error        = error_q;
  assign bus.taken        = taken_q;
  assign bus.cond_bits    = cond_bits_q;
  assign bus.ra_sel       = ra_sel_q;
  assign bus.c_sext       = c_sext_q;
  assign bus.rout         = rout;
  assign bus.con_in       = con_in;
  assign bus.pc_out       = pc_out;
  assign bus.y_in         = y_in;
  assign bus.c_out        = c_out;
  assign bus.alu_add      = alu_add;
  assign bus.z_in         = z_in;
  assign bus.zlow_out     = zlow_out;
  assign bus.pc_in        = pc_in;
  assign bus.taken_cnt    = taken_cnt_q;
  assign bus.nottaken_cnt = nottaken_cnt_q;
  assign bus.state_dbg    = state;

endmodule

// File: tb/tb_branch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_branch_sequencer
//   Drives two sequencers from the same stimulus. One uses 16-bit counters.
//   The other uses 2-bit counters, so saturation can be exercised.
//
//   The reference model works at transaction level. When a start is accepted,
//   the bench pushes the whole expected per-cycle picture of the branch onto
//   exp_q: status bits plus strobes. It derives this from the branch's outcome
//   and its cycle-by-cycle schedule. Counters and latched fields are tracked
//   as plain integers.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_branch_sequencer;

  localparam logic [4:0] BR = 5'b10010;

  // observation word: {busy, done, error, taken, rout, con_in, pc_out, y_in,
  //                    c_out, alu_add, z_in, zlow_out, pc_in}
  localparam logic [8:0] ST_CON  = 9'b110000000;
  localparam logic [8:0] ST_PC   = 9'b001100000;
  localparam logic [8:0] ST_ADD  = 9'b000011100;
  localparam logic [8:0] ST_LOAD = 9'b000000011;
  localparam logic [8:0] ST_NONE = 9'b000000000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] ir = 32'h0;
  logic        con_out = 1'b0;

  always #5 clk = ~clk;

  branch_sequencer_if #(.DATA_WIDTH(32), .CNT_WIDTH(16)) bus16 ();
  branch_sequencer_if #(.DATA_WIDTH(32), .CNT_WIDTH(2))  bus2 ();

  assign bus16.start   = start;
  assign bus16.ir      = ir;
  assign bus16.con_out = con_out;
  assign bus2.start    = start;
  assign bus2.ir       = ir;
  assign bus2.con_out  = con_out;

  branch_sequencer #(.DATA_WIDTH(32), .CNT_WIDTH(16), .BR_OPCODE(BR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16)
  );

  branch_sequencer #(.DATA_WIDTH(32), .CNT_WIDTH(2), .BR_OPCODE(BR)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  // ---------------- scoreboard / model ----------------
  logic [12:0] exp_q[$];
  logic [12:0] cur;
  logic        m_taken;
  int          m_tcnt;
  int          m_ncnt;
  logic [3:0]  m_ra;
  logic [1:0]  m_cond;
  logic [31:0] m_csext;
  int          since_acc;
  logic        plan_cond;
  logic        next_cond;
  int          compared = 0;
  int          mismatched = 0;

  function automatic logic [12:0] idle_word(input logic err);
    return {1'b0, 1'b0, err, m_taken, ST_NONE};
  endfunction

  function automatic logic [15:0] sat16(input int v);
    return (v > 65535) ? 16'hFFFF : 16'(v);
  endfunction

  function automatic logic [1:0] sat2(input int v);
    return (v > 3) ? 2'd3 : 2'(v);
  endfunction

  function automatic logic [12:0] obs16();
    return {bus16.busy, bus16.done, bus16.error, bus16.taken, bus16.rout,
            bus16.con_in, bus16.pc_out, bus16.y_in, bus16.c_out, bus16.alu_add,
            bus16.z_in, bus16.zlow_out, bus16.pc_in};
  endfunction

  function automatic logic [86:0] obs_all();
    return {obs16(), bus16.taken_cnt, bus16.nottaken_cnt, bus2.taken_cnt,
            bus2.nottaken_cnt, bus16.ra_sel, bus16.cond_bits, bus16.c_sext};
  endfunction

  function automatic logic [86:0] exp_all();
    return {cur, sat16(m_tcnt), sat16(m_ncnt), sat2(m_tcnt), sat2(m_ncnt),
            m_ra, m_cond, m_csext};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    reset = 1'b1; start = 1'b0; ir = 32'h0; con_out = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    m_taken = 1'b0; m_tcnt = 0; m_ncnt = 0;
    m_ra = 4'h0; m_cond = 2'b00; m_csext = 32'h0;
    since_acc = 99;
    cur = idle_word(1'b0);
  endtask

  // Drives one cycle of inputs and updates the model. Returns #1 after the
  // next rising edge, with cur holding what the DUT should show.
  task automatic cycle(input logic s, input logic [31:0] i);
    start = s;
    ir = i;
    con_out = (since_acc == 2) ? plan_cond : 1'($urandom_range(0, 1));
    if (s && !cur[12]) begin
      if (i[31:27] == BR) begin
        plan_cond = next_cond;
        since_acc = 0;
        m_ra = i[26:23];
        m_cond = i[20:19];
        m_csext = {13'h0, i[18:0]};
        if (i[18]) m_csext = m_csext - 32'h0008_0000;
        exp_q.push_back({4'b1000, ST_CON});
        exp_q.push_back({4'b1000, ST_NONE});
        if (plan_cond) begin
          exp_q.push_back({4'b1001, ST_PC});
          exp_q.push_back({4'b1001, ST_ADD});
          exp_q.push_back({4'b1001, ST_LOAD});
          exp_q.push_back({4'b1101, ST_NONE});
        end else begin
          exp_q.push_back({4'b1100, ST_NONE});
        end
        m_taken = plan_cond;
      end else begin
        exp_q.push_back(idle_word(1'b1));
      end
    end
    @(posedge clk); #1;
    since_acc++;
    cur = (exp_q.size() > 0) ? exp_q.pop_front() : idle_word(1'b0);
    if (cur[11]) begin
      if (cur[9]) m_tcnt++;
      else m_ncnt++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    if (obs_all() !== exp_all()) begin
      mismatched++;
      $display("FAIL reset_state got=%h exp=%h", obs_all(), exp_all());
    end
    compared++;
    if (bus16.state_dbg !== 3'd0 || bus16.busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_idle got state=%0d busy=%b exp state=0 busy=0", bus16.state_dbg, bus16.busy);
    end
    compared++;
  endtask

  task automatic test_taken();
    apply_reset();
    next_cond = 1'b1;
    for (int k = 0; k < 9; k++) begin
      cycle(k == 0, (k == 0) ? 32'h9107FFFC : $urandom);
      if (obs_all() !== exp_all()) begin
        mismatched++;
        $display("FAIL taken cyc=%0d got=%h exp=%h", k + 1, obs_all(), exp_all());
      end
      compared++;
      if (k + 1 == 1) begin
        if ({bus16.ra_sel, bus16.cond_bits, bus16.c_sext, bus16.rout, bus16.con_in}
            !== {4'd2, 2'b00, 32'hFFFFFFFC, 1'b1, 1'b1}) begin
          mismatched++;
          $display("FAIL taken_fields got ra=%0d cond=%b c=%h rout=%b con_in=%b exp ra=2 cond=00 c=fffffffc 1 1",
                   bus16.ra_sel, bus16.cond_bits, bus16.c_sext, bus16.rout, bus16.con_in);
        end
        compared++;
      end
      if (k + 1 == 6) begin
        if ({bus16.done, bus16.taken, bus16.taken_cnt} !== {1'b1, 1'b1, 16'd1}) begin
          mismatched++;
          $display("FAIL taken_done got done=%b taken=%b cnt=%0d exp 1 1 1",
                   bus16.done, bus16.taken, bus16.taken_cnt);
        end
        compared++;
      end
    end
  endtask

  task automatic test_not_taken();
    logic seen;
    seen = 1'b0;
    apply_reset();
    next_cond = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cycle(k == 0, (k == 0) ? 32'h9107FFFC : $urandom);
      seen = seen | bus16.pc_out | bus16.y_in | bus16.c_out | bus16.z_in | bus16.pc_in;
      if (obs_all() !== exp_all()) begin
        mismatched++;
        $display("FAIL not_taken cyc=%0d got=%h exp=%h", k + 1, obs_all(), exp_all());
      end
      compared++;
      if (k + 1 == 3) begin
        if ({bus16.done, bus16.taken, bus16.nottaken_cnt} !== {1'b1, 1'b0, 16'd1}) begin
          mismatched++;
          $display("FAIL not_taken_done got done=%b taken=%b ncnt=%0d exp 1 0 1",
                   bus16.done, bus16.taken, bus16.nottaken_cnt);
        end
        compared++;
      end
    end
    if (seen !== 1'b0) begin
      mismatched++;
      $display("FAIL not_taken_strobes got=%b exp=0", seen);
    end
    compared++;
  endtask

  task automatic test_illegal();
    // Fields still hold ra=2 and c=-4 from the previous branch.
    for (int k = 0; k < 3; k++) begin
      cycle(k == 0, (k == 0) ? 32'h19000000 : $urandom);
      if (obs_all() !== exp_all()) begin
        mismatched++;
        $display("FAIL illegal cyc=%0d got=%h exp=%h", k + 1, obs_all(), exp_all());
      end
      compared++;
      if ({bus16.error, bus16.busy, bus16.ra_sel, bus16.c_sext}
          !== {(k == 0), 1'b0, 4'd2, 32'hFFFFFFFC}) begin
        mismatched++;
        $display("FAIL illegal_err cyc=%0d got err=%b busy=%b ra=%0d c=%h exp err=%b busy=0 ra=2 c=fffffffc",
                 k + 1, bus16.error, bus16.busy, bus16.ra_sel, bus16.c_sext, (k == 0));
      end
      compared++;
    end
  endtask

  task automatic test_busy_start();
    int dones;
    dones = 0;
    apply_reset();
    next_cond = 1'b1;
    for (int k = 0; k < 9; k++) begin
      cycle(k == 0 || k == 2, (k == 0) ? 32'h9107FFFC : ((k == 2) ? 32'h91880005 : $urandom));
      if (bus16.done === 1'b1) dones++;
      if (obs_all() !== exp_all()) begin
        mismatched++;
        $display("FAIL busy_start cyc=%0d got=%h exp=%h", k + 1, obs_all(), exp_all());
      end
      compared++;
    end
    if (dones != 1 || bus16.ra_sel !== 4'd2) begin
      mismatched++;
      $display("FAIL busy_start_once got dones=%0d ra=%0d exp dones=1 ra=2", dones, bus16.ra_sel);
    end
    compared++;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    next_cond = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle(k == 0, (k == 0) ? 32'h9107FFFC : $urandom);
      if (obs_all() !== exp_all()) begin
        mismatched++;
        $display("FAIL reset_mid_pre cyc=%0d got=%h exp=%h", k + 1, obs_all(), exp_all());
      end
      compared++;
    end
    if (bus16.z_in !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_mid_add got z_in=%b exp=1", bus16.z_in);
    end
    compared++;
    apply_reset();
    if ({obs16(), bus16.taken_cnt, bus16.nottaken_cnt, bus16.state_dbg} !== 35'd0) begin
      mismatched++;
      $display("FAIL reset_mid_idle got=%h exp=0", {obs16(), bus16.taken_cnt, bus16.nottaken_cnt, bus16.state_dbg});
    end
    compared++;
    // Three quiet cycles, then a fresh branch that must complete normally.
    for (int k = 0; k < 10; k++) begin
      cycle(k == 3, (k == 3) ? 32'h9107FFFC : $urandom);
      if (obs_all() !== exp_all()) begin
        mismatched++;
        $display("FAIL reset_mid_post cyc=%0d got=%h exp=%h", k, obs_all(), exp_all());
      end
      compared++;
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] sat_tbl [5];
    int dones;
    int last_done;
    sat_tbl = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    dones = 0;
    last_done = -1;
    apply_reset();
    next_cond = 1'b1;
    // start held high. Only the cycle after each done may accept it.
    for (int k = 0; k < 50 && dones < 5; k++) begin
      cycle(1'b1, {BR, 27'($urandom)});
      if (obs_all() !== exp_all()) begin
        mismatched++;
        $display("FAIL b2b cyc=%0d got=%h exp=%h", k + 1, obs_all(), exp_all());
      end
      compared++;
      if (cur[11]) begin
        if (bus2.taken_cnt !== sat_tbl[dones] || bus16.done !== 1'b1 ||
            (last_done >= 0 && k - last_done != 7)) begin
          mismatched++;
          $display("FAIL sat_cnt n=%0d got cnt=%0d done=%b gap=%0d exp cnt=%0d done=1 gap=7",
                   dones, bus2.taken_cnt, bus16.done, k - last_done, sat_tbl[dones]);
        end
        compared++;
        last_done = k;
        dones++;
      end
    end
    if (dones != 5) begin
      mismatched++;
      $display("FAIL b2b_count got=%0d exp=5", dones);
    end
    compared++;
  endtask

  task automatic test_random();
    logic [31:0] i;
    apply_reset();
    for (int k = 0; k < 600; k++) begin
      i = $urandom;
      if ($urandom_range(0, 1) == 1) i[31:27] = BR;
      next_cond = 1'($urandom_range(0, 1));
      cycle($urandom_range(0, 2) == 0, i);
      if (obs_all() !== exp_all()) begin
        mismatched++;
        $display("FAIL random cyc=%0d got=%h exp=%h", k, obs_all(), exp_all());
      end
      compared++;
      if ((32'(bus16.rout) + 32'(bus16.pc_out) + 32'(bus16.c_out) + 32'(bus16.zlow_out)) > 1) begin
        mismatched++;
        $display("FAIL bus_excl cyc=%0d got rout=%b pc_out=%b c_out=%b zlow_out=%b exp at most one",
                 k, bus16.rout, bus16.pc_out, bus16.c_out, bus16.zlow_out);
      end
      compared++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    plan_cond = 1'b0;
    next_cond = 1'b0;
    since_acc = 99;
    cur = 13'h0;
    test_reset();
    test_taken();
    test_not_taken();
    test_illegal();
    test_busy_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
- Multi-cycle control FSM that consumes the condition flip-flop result and completes conditional branches (brzr/brnz/brpl/brmi) in the datapath.
- Accepts a branch IR from the main control unit and sequences Ra onto the bus with the CON strobe.
- Samples the latched condition, then conditionally computes PC <= PC + sign-extended C and loads PC.
- Counts taken and not-taken branches for debug readback.

Parameters:
- DATA_WIDTH, 32, bus/IR/offset width.
- CNT_WIDTH, 16, width of each branch statistics counter.
- BR_OPCODE, 5'b10010, IR[31:27] value identifying a branch.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears FSM, strobes, counters.
- start  input  1  one-cycle request from main control; IR valid same cycle.
- ir  input  DATA_WIDTH  instruction word (op[31:27], Ra[26:23], C2[20:19], C[18:0]).
- con_out  input  1  condition flip-flop output.
- busy  output  1  high in every non-IDLE state.
- done  output  1  one-cycle pulse at sequence completion.
- error  output  1  one-cycle pulse when start carries a non-branch opcode.
- taken  output  1  branch outcome; valid from done, held until next accepted start.
- cond_bits  output  2  latched IR[20:19], drives the condition decoder select.
- ra_sel  output  4  latched IR[26:23], register select for Gra/Rout.
- c_sext  output  DATA_WIDTH  latched IR[18:0] sign-extended from bit 18.
- rout  output  1  Ra onto bus.
- con_in  output  1  condition flip-flop capture strobe.
- pc_out  output  1  PC onto bus.
- y_in  output  1  load Y register.
- c_out  output  1  c_sext onto bus.
- alu_add  output  1  ALU operation select = ADD.
- z_in  output  1  load Z register.
- zlow_out  output  1  Z[31:0] onto bus.
- pc_in  output  1  load PC from bus.
- taken_cnt  output  CNT_WIDTH  count of taken branches.
- nottaken_cnt  output  CNT_WIDTH  count of not-taken branches.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Latched ir fields 0.
- States: IDLE, CON, EVAL, PC, ADD, LOAD, DONE.
- Strobes are decoded purely from the registered state, so there is no combinational path from inputs to strobes.
- IDLE:
  - start=1 with ir[31:27]==BR_OPCODE: latch ir fields, clear taken, go to CON.
  - start=1 with any other opcode: pulse error next cycle, stay IDLE, fields not latched.
- CON: rout=1, con_in=1 for exactly one cycle -> EVAL.
- EVAL:
  - All strobes 0; sample con_out at the end of the cycle.
  - con_out=1: set taken, go to PC.
  - con_out=0: go to DONE.
- PC: pc_out=1, y_in=1 -> ADD.
- ADD: c_out=1, alu_add=1, z_in=1 -> LOAD.
- LOAD: zlow_out=1, pc_in=1 -> DONE.
- DONE:
  - done=1 for one cycle.
  - Increment taken_cnt or nottaken_cnt according to taken.
  - Go to IDLE.
- Latency, with start accepted in cycle n:
  - Taken: done in cycle n+6.
  - Not taken: done in cycle n+3.
  - busy is high from n+1 through the done cycle inclusive.
- start while busy: ignored; no state, field or error change.
- start is sampled in IDLE only; it may be asserted in the cycle immediately after done.
- Counters saturate at all-ones and never wrap.
- Reset mid-sequence:
  - Next cycle is IDLE with all strobes low, counters 0, taken 0.
  - No partial PC load is emitted after reset.
- No two bus-drive strobes (rout, pc_out, c_out, zlow_out) are ever high in the same cycle.
- c_sext: bits [DATA_WIDTH-1:19] equal IR[18].

Test Plan:
- Taken branch: reset, start with ir=0x9107FFFC (brzr R2, C=-4), con_out=1 during EVAL.
  - Cycle n+1: ra_sel=2, cond_bits=00, c_sext=0xFFFFFFFC, rout=con_in=1.
  - Cycles n+3/n+4/n+5: PC, ADD, LOAD strobes.
  - Cycle n+6: done=1, taken=1, taken_cnt=1.
- Not taken: same ir, con_out=0.
  - done at n+3, taken=0.
  - pc_out/y_in/c_out/z_in/pc_in never asserted.
  - nottaken_cnt=1.
- Illegal opcode: start with ir=0x19000000 (op 00011).
  - error pulses once at n+1.
  - busy stays 0; ra_sel/c_sext keep prior values.
- start while busy: second start (ir=0x91880005) at n+2 of a taken sequence.
  - Ignored; ra_sel stays 2; exactly one done.
- Reset mid-sequence: assert reset in ADD state.
  - Next cycle: all strobes 0, state IDLE, counters 0.
  - A fresh start then completes normally.
- Counter saturation: CNT_WIDTH=2, run 5 taken branches.
  - taken_cnt reads 1, 2, 3, 3, 3.
  - Back-to-back start on the cycle after done is accepted each time.
